burst_packer: RTL

BURST_PACKER -- requirements
Module: burst_packer

---
 rtl/burst_packer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/burst_packer.sv
// Collects 4-beat memory read bursts into packets and queues them in a small FIFO
// toward a crossbar port. Define BURST_PACKER_PARITY_EN to add the pkt_par output.
module burst_packer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_vld,
    input  logic            rd_first,
    input  logic [DW-1:0]   rd_data,
    output logic            req,
    output logic            pkt_valid,
    input  logic            pkt_ready,
    output logic [4*DW-1:0] pkt_data,
    output logic [1:0]      pkt_dest,
    output logic            err,
`ifdef BURST_PACKER_PARITY_EN
    output logic            ovf,
    output logic            pkt_par
`else
    output logic            ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      beat_cnt_q, beat_cnt_d;
    logic [2:0]      beat_we;
    logic            complete;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            push_q, push_d;
    logic            req_q, req_d;
    logic [DW-1:0]   beats_q [3];
    logic [4*DW-1:0] pend_q;
    logic [4*DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            full;
    logic            pop;
    logic            push_acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            push_q     <= 1'b0;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            push_q     <= push_d;
            req_q      <= req_d;
            count_q    <= count_d;
            if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // A new rd_first always restarts assembly at beat 0, whatever the state.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        beat_we    = 3'b000;
        complete   = 1'b0;
        if (rd_vld) begin
            case (state_q)
                IDLE: begin
                    if (rd_first) begin
                        state_d    = COLLECT;
                        beat_cnt_d = 2'd1;
                        beat_we    = 3'b001;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (rd_first) begin
                        err_d      = 1'b1;
                        beat_cnt_d = 2'd1;
                        beat_we    = 3'b001;
                    end else if (beat_cnt_q == 2'd3) begin
                        complete   = 1'b1;
                        state_d    = IDLE;
                        beat_cnt_d = 2'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                        beat_we    = 3'b001 << beat_cnt_q;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    beat_cnt_d = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        full     = (count_q == FULL);
        pop      = pkt_valid && pkt_ready;
        push_acc = push_q && (!full || pop);
        push_d   = complete;
        ovf_d    = ovf_q || (push_q && full && !pop);
        count_d  = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_acc && pop) begin
            count_d = count_q - CW'(1);
        end
        req_d = (state_d == IDLE) && !push_d && (count_d < FULL);
    end

    // Beat 3 goes straight into the staging register; it is never held in beats_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (beat_we[i]) beats_q[i] <= rd_data;
        end
        if (complete) pend_q <= {rd_data, beats_q[2], beats_q[1], beats_q[0]};
        if (push_acc) mem_q[wr_ptr_q] <= pend_q;
    end

    assign pkt_valid = (count_q != '0);
    assign pkt_data  = pkt_valid ? mem_q[rd_ptr_q] : '0;
    assign pkt_dest  = pkt_data[1:0];
    assign req       = req_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

`ifdef BURST_PACKER_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push_acc) par_q[wr_ptr_q] <= ^pend_q;
    end

    assign pkt_par = pkt_valid ? par_q[rd_ptr_q] : 1'b0;
`endif

endmodule
